button_ctrl: RTL and testbench
==============================

# button_ctrl

User push-button front end for the I2C monitor. It synchronises and debounces the raw board button and classifies each press by duration. A short press toggles timestamp enable; a long press issues a one-cycle timestamp reset. Its outputs drive the timestamp logic and the LED controller's `i_timestamp_en` / `i_timestamp_res` inputs directly.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 240000: cycles of stable synchronised input required to accept a level change (10 ms at 24 MHz). Legal range is ≥1.
- `LONG_CYC`, default 24000000: debounced hold cycles that make a press long (1 s at 24 MHz). Must be greater than `DEBOUNCE_CYC`.
- `TS_EN_INIT`, default 1: value of `o_timestamp_en` after reset.

Ports:
- `i_clk`, input, 1: system clock; the only clock in the block.
- `i_res_n`, input, 1: reset. Synchronous, active-low.
- `i_btn_n`, input, 1: raw button, low = pressed. Asynchronous and may bounce.
- `o_btn_db`, output, 1: debounced level, 1 = pressed. For debug.
- `o_timestamp_en`, output, 1: timestamp enable level.
- `o_timestamp_res`, output, 1: timestamp reset request, exactly one cycle wide.

## Operation
- **Reset** (sampled on `i_clk` while `i_res_n`=0):
  - Both synchroniser flops go to 1 (released).
  - Debounce counter = 0; `o_btn_db` = 0.
  - Hold counter = 0; state = IDLE.
  - `o_timestamp_en` = `TS_EN_INIT`; `o_timestamp_res` = 0.
- **Synchroniser:** two flops on `i_btn_n`. The second flop's output, inverted, is `s_press`.
- **Debounce:**
  - While `s_press` == `o_btn_db`, the counter is held at 0.
  - Otherwise it increments each cycle. When it reaches `DEBOUNCE_CYC`-1 with `s_press` still differing, `o_btn_db` <= `s_press` and the counter clears.
  - Any return to equality before that clears the counter. Glitches shorter than `DEBOUNCE_CYC` cycles never reach `o_btn_db`.
- **Press FSM:** the hold counter is sized to reach `LONG_CYC` and saturates.
  - IDLE: on the rising edge of `o_btn_db` -> PRESSED, hold counter = 0.
  - PRESSED:
    - The hold counter increments each cycle.
    - On the falling edge of `o_btn_db` -> IDLE and `o_timestamp_en` toggles.
    - If the hold counter reaches `LONG_CYC`-1 first -> LONG and `o_timestamp_res` = 1 for the next cycle only.
  - LONG: no further pulses or toggles. On the falling edge of `o_btn_db` -> IDLE.
- A long press never toggles the enable. A short press never pulses the reset.
- All outputs are registered, with no combinational paths from `i_btn_n`.
- Counter widths: `$clog2(param+1)` bits, unsigned. No wrap is possible because counters clear or saturate.

## Timing
- `i_btn_n` edge to `o_btn_db` change: 2 + `DEBOUNCE_CYC` cycles, given a clean edge.
- `o_btn_db` rise to `o_timestamp_res` high: exactly `LONG_CYC` cycles, held continuously.
- `o_btn_db` fall to `o_timestamp_en` toggled: 1 cycle.
- Release on the same cycle the hold counter hits `LONG_CYC`-1: the release wins. The press is short, giving a toggle and no pulse.
- Button held through reset release: it is treated as a new press. `o_btn_db` rises `DEBOUNCE_CYC`+2 cycles after reset deasserts, then normal classification applies.
- Reset asserted mid-press (any state): everything returns to reset values on the next edge. Any pending pulse or toggle is discarded.
- Back-to-back presses are accepted with no dead time beyond debounce.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `LONG_CYC`=20, `TS_EN_INIT`=1.
- **Reset values:** hold reset 3 cycles with the button released -> `o_timestamp_en`=1, `o_timestamp_res`=0, `o_btn_db`=0.
- **Bounce rejection:** apply 3-cycle low glitches on `i_btn_n`, repeated 5 times -> `o_btn_db` stays 0, no toggle.
- **Short press:** hold low 10 cycles, then release cleanly -> `o_btn_db` high for 10 cycles, `o_timestamp_en` 1->0 one cycle after `o_btn_db` falls, no pulse. A second identical press -> back to 1.
- **Long press:** hold low 40 cycles -> exactly one `o_timestamp_res` pulse, 20 cycles after `o_btn_db` rises. `o_timestamp_en` is unchanged after release.
- **Boundary:** release timed so `o_btn_db` falls on the cycle the hold counter equals 19 -> toggle occurs, no pulse. Release one cycle later -> pulse, no toggle.
- **Reset mid-press:** assert reset 15 cycles into a hold, then release reset with the button still low -> no pulse before reset. A fresh press is detected 6 cycles later, and a pulse follows 20 cycles after that.

Source files
------------

// File: rtl/button_ctrl.sv
// button_ctrl: synchronises and debounces the board button, classifying presses
// as short (toggle timestamp enable) or long (one-cycle timestamp reset pulse).
module button_ctrl #(
    parameter int DEBOUNCE_CYC = 240000,
    parameter int LONG_CYC     = 24000000,
    parameter bit TS_EN_INIT   = 1'b1
) (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_btn_n,
    output logic o_btn_db,
    output logic o_timestamp_en,
    output logic o_timestamp_res
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    logic          r_sync1, r_sync2;
    logic [DW-1:0] r_db_cnt;
    logic [HW-1:0] r_hold;
    state_t        r_state;
    logic          w_press, w_differ, w_accept, w_rise;

    assign w_press  = ~r_sync2;
    assign w_differ = w_press != o_btn_db;
    assign w_accept = w_differ && r_db_cnt == DW'(DEBOUNCE_CYC - 1);
    assign w_rise   = w_accept && w_press;

    // The press FSM starts timing on the same edge the debounced level rises,
    // so the long-press pulse lands exactly LONG_CYC cycles after o_btn_db rises.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_db_cnt        <= '0;
            o_btn_db        <= 1'b0;
            r_hold          <= '0;
            r_state         <= IDLE;
            o_timestamp_en  <= TS_EN_INIT;
            o_timestamp_res <= 1'b0;
        end else begin
            r_sync1         <= i_btn_n;
            r_sync2         <= r_sync1;
            r_db_cnt        <= (w_differ && !w_accept) ? r_db_cnt + 1'b1 : '0;
            o_timestamp_res <= 1'b0;
            if (w_accept)
                o_btn_db <= w_press;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESSED;
                        r_hold  <= '0;
                    end
                end
                PRESSED: begin
                    if (!o_btn_db) begin
                        r_state        <= w_rise ? PRESSED : IDLE;
                        r_hold         <= '0;
                        o_timestamp_en <= ~o_timestamp_en;
                    end else if (r_hold == HW'(LONG_CYC - 1)) begin
                        r_state         <= LONG;
                        o_timestamp_res <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    if (!o_btn_db) begin
                        r_state <= w_rise ? PRESSED : IDLE;
                        r_hold  <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed and random button traces checked every cycle against
// a timestamp-based behavioural model of debounce and press classification.
module tb_button_ctrl;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic i_res_n = 1'b0;
    logic i_btn_n = 1'b1;
    logic o_btn_db, o_timestamp_en, o_timestamp_res;

    int n_chk = 0;
    int n_err = 0;

    button_ctrl #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .TS_EN_INIT(1'b1)) dut (
        .i_clk(clk),
        .i_res_n(i_res_n),
        .i_btn_n(i_btn_n),
        .o_btn_db(o_btn_db),
        .o_timestamp_en(o_timestamp_en),
        .o_timestamp_res(o_timestamp_res)
    );

    always #5 clk = ~clk;

    // Model: the debounced level follows the synchronised press once it has
    // disagreed for DEB cycles; a press is long when it lasts LONG cycles.
    int cyc = 0;
    bit m_s1 = 1, m_s2 = 1, m_db = 0, m_en = 1, m_res = 0;
    int run = 0, rise_at = -1000, fall_at = -1000;
    int dut_p = 0, db_hi = 0;

    task automatic model(input bit b, input bit r);
        bit sp;
        if (!r) begin
            m_s1 = 1; m_s2 = 1; m_db = 0; run = 0;
            m_en = 1; m_res = 0; fall_at = -1000;
        end else begin
            sp    = !m_s2;
            m_s2  = m_s1;
            m_s1  = b;
            m_res = m_db && (cyc - rise_at == LONG);
            if (fall_at == cyc - 1 && fall_at - rise_at < LONG)
                m_en = !m_en;
            run = (sp != m_db) ? run + 1 : 0;
            if (run == DEB) begin
                m_db = sp;
                run  = 0;
                if (sp) rise_at = cyc;
                else    fall_at = cyc;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic b, input logic r);
        i_btn_n = b;
        i_res_n = r;
        @(posedge clk);
        model(b, r);
        #1;
        chk("db", o_btn_db, m_db);
        chk("en", o_timestamp_en, m_en);
        chk("res", o_timestamp_res, m_res);
        if (o_timestamp_res) dut_p++;
        if (o_btn_db) db_hi++;
    endtask

    task automatic hold(input logic b, input int n);
        repeat (n) tick(b, 1'b1);
    endtask

    initial begin
        int p0, h0, k;
        logic e0, rb, rr;
        int len;
        repeat (3) tick(1'b1, 1'b0);
        chk("reset_en", o_timestamp_en, 1'b1);
        chk("reset_res", o_timestamp_res, 1'b0);
        chk("reset_db", o_btn_db, 1'b0);

        h0 = db_hi;
        repeat (5) begin
            hold(1'b0, 3);
            hold(1'b1, $urandom_range(3, 6));
        end
        chk_i("glitch_db_high", db_hi - h0, 0);
        chk("glitch_en", o_timestamp_en, 1'b1);

        for (int i = 0; i < 2; i++) begin
            p0 = dut_p; h0 = db_hi;
            hold(1'b0, 10);
            hold(1'b1, 12);
            chk_i("short_db_len", db_hi - h0, 10);
            chk_i("short_pulses", dut_p - p0, 0);
            chk("short_en", o_timestamp_en, i == 0 ? 1'b0 : 1'b1);
        end

        p0 = dut_p; e0 = o_timestamp_en;
        hold(1'b0, 40);
        hold(1'b1, 12);
        chk_i("long_pulses", dut_p - p0, 1);
        chk("long_en", o_timestamp_en, e0);

        p0 = dut_p; e0 = o_timestamp_en;
        hold(1'b0, LONG - 1);
        hold(1'b1, 12);
        chk_i("edge19_pulses", dut_p - p0, 0);
        chk("edge19_en", o_timestamp_en, ~e0);

        p0 = dut_p; e0 = o_timestamp_en;
        hold(1'b0, LONG);
        hold(1'b1, 12);
        chk_i("edge20_pulses", dut_p - p0, 1);
        chk("edge20_en", o_timestamp_en, e0);

        p0 = dut_p;
        hold(1'b0, 15);
        repeat (3) tick(1'b0, 1'b0);
        chk_i("midrst_pulses", dut_p - p0, 0);
        k = 0;
        while (!o_btn_db && k < 50) begin
            tick(1'b0, 1'b1);
            k++;
        end
        chk_i("midrst_redetect", k, DEB + 2);
        k = 0;
        while (!o_timestamp_res && k < 50) begin
            tick(1'b0, 1'b1);
            k++;
        end
        chk_i("midrst_long", k, LONG);
        hold(1'b1, 12);

        for (int i = 0; i < 60; i++) begin
            rb  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 19) != 0);
            len = rr ? $urandom_range(1, 30) : 2;
            repeat (len) tick(rb, rr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
